// File: rtl/linear_pkg.sv
// Shared types and limits for the linear-engine scheduler.
package linear_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StComplete,
        StErr
    } state_e;

    localparam int unsigned LIN_MAX_ROWS = 50;
    localparam int unsigned LIN_MAX_COLS = 20;
    localparam int unsigned LIN_ROW_W    = 6;
    localparam int unsigned LIN_COL_W    = 5;
    // Widest base address a job can carry; the top slices down to ADDR_W.
    localparam int unsigned LIN_BASE_W   = 32;

    typedef struct packed {
        logic [LIN_ROW_W-1:0]  rows;
        logic [LIN_COL_W-1:0]  cols;
        logic [LIN_BASE_W-1:0] in_base;
        logic [LIN_BASE_W-1:0] w_base;
        logic [LIN_BASE_W-1:0] out_base;
    } job_t;

    function automatic logic job_invalid(logic [LIN_ROW_W-1:0] rows, logic [LIN_COL_W-1:0] cols);
        return (rows == '0) || (cols == '0) ||
               (32'(rows) > LIN_MAX_ROWS) || (32'(cols) > LIN_MAX_COLS);
    endfunction

endpackage

// File: rtl/linear_sched_if.sv
// Requester/engine bundle of the linear scheduler; slave = scheduler side.
interface linear_sched_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 16
) ();
    import linear_pkg::*;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*LIN_ROW_W-1:0] req_rows;
    logic [NUM_REQ*LIN_COL_W-1:0] req_cols;
    logic [NUM_REQ*ADDR_W-1:0]    req_in_base;
    logic [NUM_REQ*ADDR_W-1:0]    req_w_base;
    logic [NUM_REQ*ADDR_W-1:0]    req_out_base;
    logic                         eng_start;
    logic [LIN_ROW_W-1:0]         eng_rows;
    logic [LIN_COL_W-1:0]         eng_cols;
    logic [ADDR_W-1:0]            eng_in_base;
    logic [ADDR_W-1:0]            eng_w_base;
    logic [ADDR_W-1:0]            eng_out_base;
    logic                         eng_done;
    logic [NUM_REQ-1:0]           cmp_valid;

    modport slave (
        input  req_valid, req_rows, req_cols, req_in_base, req_w_base, req_out_base, eng_done,
        output req_ready, eng_start, eng_rows, eng_cols, eng_in_base, eng_w_base, eng_out_base,
               cmp_valid
    );

    modport master (
        output req_valid, req_rows, req_cols, req_in_base, req_w_base, req_out_base, eng_done,
        input  req_ready, eng_start, eng_rows, eng_cols, eng_in_base, eng_w_base, eng_out_base,
               cmp_valid
    );
endinterface

// File: rtl/linear_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr_i.
module linear_rr_arb #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IdxW    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               any_o
);
    int unsigned cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_i) + i) % NUM_REQ;
            if (!any_o && valid_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end
endmodule

// File: rtl/linear_sched.sv
// Round-robin scheduler sharing one linear engine among NUM_REQ requesters (ADDR_W <= 32).
// Optional watchdog/ERR state is built when LINEAR_SCHED_TIMEOUT_EN is defined.
module linear_sched
    import linear_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 65535,
    localparam int unsigned IdxW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    linear_sched_if.slave   bus,
    output logic [IdxW-1:0] grant_id,
    output logic            busy,
    output logic            err_timeout
);
    state_e             state_q, state_d;
    logic [IdxW-1:0]    rr_q, rr_d;
    logic [IdxW-1:0]    grant_q, grant_d;
    job_t               job_q, job_d, sel_job;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IdxW-1:0]    arb_idx;
    logic               arb_any;
`ifdef LINEAR_SCHED_TIMEOUT_EN
    logic [31:0]        wdog_q, wdog_d;
    logic               err_q, err_d;
`endif

    linear_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_arb (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        sel_job          = '0;
        sel_job.rows     = bus.req_rows[arb_idx*LIN_ROW_W +: LIN_ROW_W];
        sel_job.cols     = bus.req_cols[arb_idx*LIN_COL_W +: LIN_COL_W];
        sel_job.in_base  = LIN_BASE_W'(bus.req_in_base[arb_idx*ADDR_W +: ADDR_W]);
        sel_job.w_base   = LIN_BASE_W'(bus.req_w_base[arb_idx*ADDR_W +: ADDR_W]);
        sel_job.out_base = LIN_BASE_W'(bus.req_out_base[arb_idx*ADDR_W +: ADDR_W]);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        job_d   = job_q;
`ifdef LINEAR_SCHED_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    job_d   = sel_job;
                    // Out-of-range jobs are acknowledged without touching the engine.
                    state_d = job_invalid(sel_job.rows, sel_job.cols) ? StComplete : StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWait;
`ifdef LINEAR_SCHED_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            StWait: begin
                if (bus.eng_done) begin
                    state_d = StComplete;
                end
`ifdef LINEAR_SCHED_TIMEOUT_EN
                // Threshold lands err_timeout exactly TIMEOUT_CYC cycles after eng_start.
                else if (wdog_q + 32'd1 >= TIMEOUT_CYC - 32'd1) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            StComplete: begin
                state_d = StIdle;
                rr_d    = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            job_q   <= '0;
`ifdef LINEAR_SCHED_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            job_q   <= job_d;
`ifdef LINEAR_SCHED_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready    = (state_q == StIdle) ? arb_gnt : '0;
    assign bus.eng_start    = (state_q == StLaunch);
    assign bus.cmp_valid    = (state_q == StComplete) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.eng_rows     = job_q.rows;
    assign bus.eng_cols     = job_q.cols;
    assign bus.eng_in_base  = job_q.in_base[ADDR_W-1:0];
    assign bus.eng_w_base   = job_q.w_base[ADDR_W-1:0];
    assign bus.eng_out_base = job_q.out_base[ADDR_W-1:0];
    assign grant_id         = grant_q;
    assign busy             = (state_q != StIdle);
`ifdef LINEAR_SCHED_TIMEOUT_EN
    assign err_timeout      = err_q;
`else
    assign err_timeout      = 1'b0;
`endif

    if (ADDR_W < LIN_BASE_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{job_q.in_base[LIN_BASE_W-1:ADDR_W], job_q.w_base[LIN_BASE_W-1:ADDR_W],
                             job_q.out_base[LIN_BASE_W-1:ADDR_W]};
    end
endmodule

// File: tb/tb_linear_sched.sv
// Self-checking bench for linear_sched: vector table plus scoreboard queues fed at stimulus time.
module tb_linear_sched;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_timeout;
    logic       eng_done_auto = 1'b0;
    logic       eng_done_man = 1'b0;

    linear_sched_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

    linear_sched #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;
    assign bus.eng_done = eng_done_auto | eng_done_man;

    typedef struct {
        int         id;
        logic [5:0] rows;
        logic [4:0] cols;
        logic [15:0] ib;
        logic [15:0] wb;
        logic [15:0] ob;
        int         lat;
        bit         launch;
    } vec_t;

    vec_t exp_acc_q[$];
    vec_t exp_start_q[$];
    vec_t exp_cmp_q[$];
    int   start_log[$];
    int   chk_cnt = 0, pass_cnt = 0, cyc = 0;
    int   acc_cnt = 0, start_cnt = 0, cmp_cnt = 0, busy_viol = 0;
    int   last_acc_cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
    int   eng_lat = 0, eng_cnt = 0;
    bit   in_job = 1'b0;
    vec_t mon_e;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [127:0] snapshot();
        return 128'({busy, err_timeout, bus.eng_start, bus.cmp_valid, bus.req_ready, grant_id,
                     bus.eng_rows, bus.eng_cols, bus.eng_in_base, bus.eng_w_base, bus.eng_out_base});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: raises eng_done eng_lat cycles after eng_start (eng_lat 0 = never).
    always @(negedge clk) begin
        #1;
        eng_done_auto = 1'b0;
        if (!rst_n) eng_cnt = 0;
        else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_done_auto = 1'b1;
            end
            if (bus.eng_start && eng_lat > 0) eng_cnt = eng_lat;
        end
    end

    // Monitor: pops scoreboard entries as the DUT produces accept/start/complete events.
    always @(negedge clk) begin
        #2;
        if (!rst_n) in_job = 1'b0;
        else begin
            if (bus.eng_done) last_done_cyc = cyc;
            if (in_job && cyc > last_acc_cyc && !busy) busy_viol++;
            if (bus.req_ready != '0) begin
                acc_cnt++;
                if (exp_acc_q.size() == 0) fail("unexpected_accept", bus.req_ready, 0);
                else begin
                    mon_e = exp_acc_q.pop_front();
                    check("accept_id", bus.req_ready, 3'b001 << mon_e.id);
                end
                last_acc_cyc = cyc;
                in_job = 1'b1;
            end
            if (bus.eng_start) begin
                start_cnt++;
                start_log.push_back(cyc);
                last_start_cyc = cyc;
                if (exp_start_q.size() == 0) fail("unexpected_start", bus.eng_start, 0);
                else begin
                    mon_e = exp_start_q.pop_front();
                    check("start_latency", cyc - last_acc_cyc, 1);
                    check("eng_fields", {grant_id, bus.eng_rows, bus.eng_cols, bus.eng_in_base,
                                         bus.eng_w_base, bus.eng_out_base},
                          {2'(mon_e.id), mon_e.rows, mon_e.cols, mon_e.ib, mon_e.wb, mon_e.ob});
                end
            end
            if (bus.cmp_valid != '0) begin
                cmp_cnt++;
                if (exp_cmp_q.size() == 0) fail("unexpected_cmp", bus.cmp_valid, 0);
                else begin
                    mon_e = exp_cmp_q.pop_front();
                    check("cmp_onehot", bus.cmp_valid, 3'b001 << mon_e.id);
                    check("cmp_latency", cyc - (mon_e.launch ? last_done_cyc : last_acc_cyc), 1);
                end
                in_job = 1'b0;
            end
        end
    end

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       return acc_cnt;
            1:       return start_cnt;
            default: return cmp_cnt;
        endcase
    endfunction

    // Called on a falling edge; returns 3 ns after the edge where the count was reached.
    task automatic wait_evt(input int sel, input int target, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            #3;
            if (get_cnt(sel) >= target) return;
            @(negedge clk);
        end
        fail(name, get_cnt(sel), target);
    endtask

    task automatic drive_job(input vec_t v, input bit push_cmp);
        bus.req_rows[v.id*6 +: 6]      = v.rows;
        bus.req_cols[v.id*5 +: 5]      = v.cols;
        bus.req_in_base[v.id*16 +: 16] = v.ib;
        bus.req_w_base[v.id*16 +: 16]  = v.wb;
        bus.req_out_base[v.id*16 +: 16] = v.ob;
        bus.req_valid[v.id]            = 1'b1;
        exp_acc_q.push_back(v);
        if (v.launch) exp_start_q.push_back(v);
        if (push_cmp) exp_cmp_q.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int a0, c0, bv0;
        a0 = acc_cnt;
        c0 = cmp_cnt;
        bv0 = busy_viol;
        eng_lat = v.lat;
        @(negedge clk);
        drive_job(v, 1'b1);
        wait_evt(0, a0 + 1, 20, "accept_wait");
        @(negedge clk);
        bus.req_valid[v.id] = 1'b0;
        wait_evt(2, c0 + 1, v.lat + 20, "complete_wait");
        @(negedge clk);
        check("busy_held", busy_viol - bv0, 0);
        check("queues_drained", exp_acc_q.size() + exp_start_q.size() + exp_cmp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_acc_q.delete();
        exp_start_q.delete();
        exp_cmp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        int a0, c0, s0;

        bus.req_valid = '0;
        bus.req_rows = '0;
        bus.req_cols = '0;
        bus.req_in_base = '0;
        bus.req_w_base = '0;
        bus.req_out_base = '0;
        repeat (3) @(negedge clk);
        #3;
        check("reset_state", snapshot(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{1, 6'd50, 5'd20, 16'h1000, 16'h2000, 16'h3000, 1000, 1'b1};
        vecs[1] = '{2, 6'd0,  5'd5,  16'h0011, 16'h0022, 16'h0033, 0,    1'b0};
        vecs[2] = '{0, 6'd1,  5'd1,  16'hA5A5, 16'h5A5A, 16'hFFFF, 1,    1'b1};
        vecs[3] = '{2, 6'd51, 5'd1,  16'h0100, 16'h0200, 16'h0300, 0,    1'b0};
        vecs[4] = '{0, 6'd10, 5'd21, 16'h0400, 16'h0500, 16'h0600, 0,    1'b0};
        vecs[5] = '{1, 6'd63, 5'd31, 16'h0700, 16'h0800, 16'h0900, 0,    1'b0};
        vecs[6] = '{2, 6'd7,  5'd0,  16'h0A00, 16'h0B00, 16'h0C00, 0,    1'b0};
        vecs[7] = '{2, 6'd33, 5'd13, 16'hBEEF, 16'hCAFE, 16'h1234, 3,    1'b1};
        foreach (vecs[i]) run_vec(vecs[i]);

        // eng_done while idle must be ignored.
        c0 = cmp_cnt;
        @(negedge clk);
        eng_done_man = 1'b1;
        @(negedge clk);
        eng_done_man = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("idle_done_busy", busy, 0);
        check("idle_done_no_cmp", cmp_cnt - c0, 0);

        // Reset during WAIT, then a late eng_done.
        @(negedge clk);
        eng_lat = 0;
        c0 = cmp_cnt;
        a0 = acc_cnt;
        v = '{0, 6'd9, 5'd9, 16'h0F0F, 16'hF0F0, 16'h00FF, 0, 1'b1};
        drive_job(v, 1'b0);
        wait_evt(0, a0 + 1, 20, "accept_wait");
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_async", snapshot(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        eng_done_man = 1'b1;
        @(negedge clk);
        eng_done_man = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("reset_late_done", snapshot(), 0);
        check("reset_no_cmp", cmp_cnt - c0, 0);

        // All three requesters continuously valid: grant order 0,1,2,0,1,2.
        @(negedge clk);
        eng_lat = 5;
        a0 = acc_cnt;
        c0 = cmp_cnt;
        s0 = start_log.size();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                v = '{i, 6'(4 + i), 5'(3 + i), 16'(16'h1100 * (i + 1)), 16'(16'h0220 * (i + 1)),
                      16'(16'h0033 * (i + 1)), 5, 1'b1};
                drive_job(v, 1'b1);
            end
        end
        wait_evt(0, a0 + 6, 100, "rr_accept_wait");
        @(negedge clk);
        bus.req_valid = '0;
        wait_evt(2, c0 + 6, 40, "rr_complete_wait");
        @(negedge clk);
        if (start_log.size() >= s0 + 6) begin
            for (int k = 1; k < 6; k++)
                check("start_spacing", start_log[s0+k] - start_log[s0+k-1], 8);
        end else fail("rr_start_count", start_log.size() - s0, 6);
        check("rr_queues_drained", exp_acc_q.size() + exp_start_q.size() + exp_cmp_q.size(), 0);

        // Engine never answers.
        @(negedge clk);
        eng_lat = 0;
        a0 = acc_cnt;
        v = '{2, 6'd20, 5'd10, 16'h0042, 16'h0043, 16'h0044, 0, 1'b1};
        drive_job(v, 1'b0);
        wait_evt(0, a0 + 1, 20, "accept_wait");
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
`ifdef LINEAR_SCHED_TIMEOUT_EN
        for (int k = 0; k < 300; k++) begin
            #3;
            if (err_timeout) break;
            @(negedge clk);
        end
        check("timeout_latency", cyc - last_start_cyc, TO);
        check("err_busy", {err_timeout, busy}, 2'b11);
        @(negedge clk);
        a0 = acc_cnt;
        c0 = cmp_cnt;
        bus.req_valid[1] = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("err_no_accept", acc_cnt - a0, 0);
        check("err_no_cmp", cmp_cnt - c0, 0);
        check("err_sticky", {err_timeout, busy}, 2'b11);
        @(negedge clk);
        bus.req_valid = '0;
`else
        repeat (150) @(negedge clk);
        #3;
        check("wait_indefinite", {err_timeout, busy}, 2'b01);
`endif
        pulse_reset();
        @(negedge clk);
        #3;
        check("final_reset", snapshot(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/linear_sched.md
LINEAR_SCHED -- requirements
Module: linear_sched

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing one linear engine (2..8).
REQ-002 Parameter ADDR_W, default 16, width of buffer base addresses.
REQ-003 Parameter TIMEOUT_CYC, default 65535, engine watchdog limit in cycles.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester job request, held until accepted.
REQ-007 req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-008 req_rows / req_cols  input  NUM_REQ*6 / NUM_REQ*5  packed job dimensions (rows 1..50, cols 1..20).
REQ-009 req_in_base / req_w_base / req_out_base  input  NUM_REQ*ADDR_W  packed buffer bases.
REQ-010 eng_start  output  1  one-cycle engine launch pulse.
REQ-011 eng_rows / eng_cols / eng_in_base / eng_w_base / eng_out_base  output  6/5/ADDR_W x3  registered job fields, stable from launch until completion.
REQ-012 eng_done  input  1  engine completion pulse.
REQ-013 cmp_valid  output  NUM_REQ  one-hot, one-cycle job-complete pulse to the owning requester.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of the current owner.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err_timeout  output  1  sticky watchdog error flag.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT, COMPLETE, ERR.
- IDLE: any req_valid triggers selection and the move to LAUNCH.
- LAUNCH: always moves to WAIT.
- WAIT: eng_done moves to COMPLETE.
- COMPLETE: always moves to IDLE.
REQ-018 Selection is round-robin: the first valid requester at or after rr_ptr wins. req_ready pulses for that requester in the same IDLE cycle, and its fields are latched into the eng_* registers.
REQ-019 After each COMPLETE, rr_ptr is set to grant_id+1, wrapping NUM_REQ-1 to 0.
REQ-020 eng_start is high only in LAUNCH, so the launch pulse comes 1 cycle after acceptance.
REQ-021 cmp_valid[grant_id] is high only in COMPLETE, 1 cycle after eng_done is sampled.
REQ-022 eng_done outside WAIT is ignored and has no effect on the FSM.
REQ-023 A job with rows==0, cols==0, rows>50 or cols>20 is still accepted.
- Scheduler goes IDLE to COMPLETE directly, with no eng_start.
- cmp_valid pulses the next cycle.
REQ-024 A requester deasserting req_valid before acceptance is legal and loses its turn without side effects.
REQ-025 Back-to-back jobs: minimum spacing between eng_start pulses is 4 cycles (IDLE, LAUNCH, WAIT with immediate done, COMPLETE).
REQ-026 A requester raising req_valid while it already owns the engine is not re-accepted until the scheduler returns to IDLE.
REQ-027 Idle requesters do not block; a lone requester is served on every IDLE opportunity.

Reset
REQ-028 While rst_n is low, and immediately on assertion:
- state=IDLE, rr_ptr=0, grant_id=0;
- all eng_* registers=0;
- eng_start, req_ready, cmp_valid, busy, err_timeout=0.
REQ-029 Reset mid-job abandons the job: no cmp_valid is issued and a late eng_done after reset release is ignored.

Configuration
REQ-030 Macro LINEAR_SCHED_TIMEOUT_EN defined, watchdog behaviour:
- A counter clears on LAUNCH and increments each WAIT cycle.
- When it reaches TIMEOUT_CYC, the FSM goes to ERR and err_timeout sets.
- In ERR, cmp_valid never pulses, requests are not accepted, and busy stays high.
- Only reset exits ERR.
REQ-031 Macro undefined: no counter or ERR logic is built, err_timeout is tied 0, and WAIT lasts indefinitely.

Structure
REQ-032 Shared package linear_pkg holds:
- the FSM state enumeration;
- LIN_MAX_ROWS=50, LIN_MAX_COLS=20, LIN_ROW_W=6, LIN_COL_W=5;
- a job struct {rows, cols, in_base, w_base, out_base}.
REQ-033 One sub-module, linear_rr_arb (combinational round-robin pick from valid vector and pointer, producing one-hot grant and index), is instantiated once.

Verification
REQ-034 Single job, requester 1: rows=50, cols=20, engine done after 1000 cycles.
- eng_start 1 cycle after req_ready[1].
- cmp_valid[1] 1 cycle after eng_done.
- busy high throughout.
REQ-035 All three requesters valid continuously, engine done after 5 cycles.
- Grant order is 0,1,2,0,1,2.
- eng_start pulses 8 cycles apart.
REQ-036 Requester 2 submits rows=0.
- No eng_start occurs.
- cmp_valid[2] pulses 1 cycle after req_ready[2].
REQ-037 rst_n pulsed low during WAIT, then eng_done driven 3 cycles after release.
- No cmp_valid is issued.
- The FSM stays in IDLE.
- All outputs are at their reset values.
REQ-038 With LINEAR_SCHED_TIMEOUT_EN and TIMEOUT_CYC=100, eng_done is never driven.
- err_timeout rises 100 cycles after eng_start.
- No later request is accepted.
REQ-039 eng_done asserted while in IDLE:
- No state change occurs.
- No cmp_valid is issued.
